fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the next-generation datapath. It replaces the single-register PC and its direct ihit-driven update with three things: a PC sequencer, a DEPTH-entry prefetch queue, and a redirect/halt path. Instruction fetch is thereby decoupled from execution. The block sits between the instruction side of `datapath_cache_if` and the decode stage, and delivers one instruction per cycle with its PC and PC+4 whenever the queue is non-empty.

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/fetch_unit_if.sv | 35 +++
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/fetch_unit.sv | 78 +++++++
 tb/tb_fetch_unit.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared datapath types for the fetch front end.
// The prefetch queue stores fetch_entry_t pairs.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        word_t inst;
        word_t pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus: instruction-cache side plus decode-side queue head.
// master = fetch unit, slave = cache/decode environment.
interface fetch_unit_if #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              ihit;
    logic [WORD_W-1:0] imemload;
    logic              imemREN;
    logic [WORD_W-1:0] imemaddr;
    logic              redirect;
    logic [WORD_W-1:0] redirect_pc;
    logic              halt;
    logic              deq;
    logic              inst_valid;
    logic [WORD_W-1:0] inst;
    logic [WORD_W-1:0] inst_pc;
    logic [WORD_W-1:0] inst_npc;
    logic [CNT_W-1:0]  count;

    modport master (
        input  ihit, imemload, redirect, redirect_pc, halt, deq,
        output imemREN, imemaddr, inst_valid, inst, inst_pc,
        output inst_npc, count
    );

    modport slave (
        output ihit, imemload, redirect, redirect_pc, halt, deq,
        input  imemREN, imemaddr, inst_valid, inst, inst_pc,
        input  inst_npc, count
    );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular queue of fetch entries with flush.
// Pointers wrap naturally; count disambiguates full from empty.
module fetch_fifo
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     din,
    output fetch_entry_t     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[head_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_push) begin
                mem_d[tail_q] = din;
                tail_d        = tail_q + 1'b1;
            end
            if (do_pop) begin
                head_d = head_q + 1'b1;
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencer, prefetch queue,
// redirect flush and sticky halt.
module fetch_unit
    import cpu_types_pkg::*;
#(
    parameter int          WORD_W  = cpu_types_pkg::WORD_W,
    parameter [WORD_W-1:0] PC_INIT = '0,
    parameter int          DEPTH   = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    fetch_unit_if.master  fif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              halted_q, halted_d;
    logic              enq;
    logic              deq_ok;
    logic              q_full;
    logic              q_empty;
    logic [CNT_W-1:0]  q_count;
    fetch_entry_t      q_din;
    fetch_entry_t      q_dout;

    // Fetch request depends only on registered state, never on deq.
    assign fif.imemREN  = nRST & ~halted_q & ~q_full;
    assign fif.imemaddr = fetch_pc_q;

    assign enq    = fif.imemREN & fif.ihit & ~fif.redirect;
    assign deq_ok = fif.deq & ~q_empty & ~fif.redirect;

    assign q_din.inst = fif.imemload;
    assign q_din.pc   = fetch_pc_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        halted_d   = halted_q | fif.halt;
        if (fif.redirect) begin
            fetch_pc_d = {fif.redirect_pc[WORD_W-1:2], 2'b00};
        end else if (enq) begin
            fetch_pc_d = fetch_pc_q + WORD_W'(4);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            fetch_pc_q <= PC_INIT;
            halted_q   <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            halted_q   <= halted_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (nRST),
        .push  (enq),
        .pop   (deq_ok),
        .flush (fif.redirect),
        .din   (q_din),
        .dout  (q_dout),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

    assign fif.inst_valid = ~q_empty;
    assign fif.inst       = q_dout.inst;
    assign fif.inst_pc    = q_dout.pc;
    assign fif.inst_npc   = q_dout.pc + WORD_W'(4);
    assign fif.count      = q_count;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a queue-level model predicts every
// cycle's outputs, a monitor compares them on the falling edge.
module tb_fetch_unit;

    localparam int DEPTH = 4;
    localparam logic [31:0] PC_INIT = 32'h0;

    typedef struct {
        bit          ren;
        logic [31:0] addr;
        bit          valid;
        int          cnt;
        logic [31:0] inst;
        logic [31:0] pc;
    } snap_t;

    logic clk;
    logic nrst;

    fetch_unit_if #(.WORD_W(32), .DEPTH(DEPTH)) bus ();

    fetch_unit #(
        .WORD_W  (32),
        .PC_INIT (PC_INIT),
        .DEPTH   (DEPTH)
    ) dut (
        .CLK  (clk),
        .nRST (nrst),
        .fif  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    snap_t       sb_q[$];
    logic [31:0] m_pc[$];
    logic [31:0] m_inst[$];
    logic [31:0] m_fpc;
    bit          m_halt;
    int          vectors;
    int          miscompares;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // One cycle: drive inputs, predict outputs, advance the model.
    task automatic step(bit rn, bit hit, bit dq, bit rd,
                        logic [31:0] rpc, bit hl);
        snap_t       s;
        logic [31:0] ld;
        bit          ren;
        @(posedge clk);
        #2;
        ld              = $urandom;
        nrst            = rn;
        bus.ihit        = hit;
        bus.imemload    = ld;
        bus.deq         = dq;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.halt        = hl;
        ren     = rn && !m_halt && (m_pc.size() != DEPTH);
        s.ren   = ren;
        s.addr  = m_fpc;
        s.valid = (m_pc.size() != 0);
        s.cnt   = m_pc.size();
        s.inst  = s.valid ? m_inst[0] : 32'h0;
        s.pc    = s.valid ? m_pc[0] : 32'h0;
        sb_q.push_back(s);
        if (!rn) begin
            m_fpc  = PC_INIT;
            m_halt = 1'b0;
            m_pc.delete();
            m_inst.delete();
        end else if (rd) begin
            m_pc.delete();
            m_inst.delete();
            m_fpc  = rpc & 32'hFFFF_FFFC;
            m_halt = m_halt | hl;
        end else begin
            if (dq && m_pc.size() != 0) begin
                void'(m_pc.pop_front());
                void'(m_inst.pop_front());
            end
            if (ren && hit) begin
                m_pc.push_back(m_fpc);
                m_inst.push_back(ld);
                m_fpc = m_fpc + 32'd4;
            end
            m_halt = m_halt | hl;
        end
    endtask

    initial begin : monitor
        snap_t s;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                s = sb_q.pop_front();
                vectors++;
                chk("imemREN", 32'(bus.imemREN), 32'(s.ren));
                chk("imemaddr", bus.imemaddr, s.addr);
                chk("inst_valid", 32'(bus.inst_valid), 32'(s.valid));
                chk("count", 32'(bus.count), s.cnt);
                if (s.valid) begin
                    chk("inst", bus.inst, s.inst);
                    chk("inst_pc", bus.inst_pc, s.pc);
                    chk("inst_npc", bus.inst_npc, s.pc + 32'd4);
                end
            end
        end
    end

    initial begin : stim
        vectors         = 0;
        miscompares     = 0;
        m_fpc           = PC_INIT;
        m_halt          = 1'b0;
        nrst            = 1'b0;
        bus.ihit        = 1'b0;
        bus.imemload    = '0;
        bus.deq         = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.halt        = 1'b0;

        // Reset, then continuous streaming
        repeat (2) step(0, 0, 0, 0, 0, 0);
        repeat (10) step(1, 1, 1, 0, 0, 0);

        // Fill to full, hold, single dequeue, resume
        step(0, 0, 0, 0, 0, 0);
        repeat (6) step(1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0, 0, 0);

        // Redirect with 3 queued, same-cycle hit and deq
        step(0, 0, 0, 0, 0, 0);
        repeat (3) step(1, 1, 0, 0, 0, 0);
        step(1, 1, 1, 1, 32'h103, 0);
        repeat (2) step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 0);

        // Halt at 0x20 with ihit, drain, redirect while halted
        step(0, 0, 0, 0, 0, 0);
        repeat (8) step(1, 1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 1);
        repeat (6) step(1, 1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 32'h40, 0);
        repeat (3) step(1, 1, 1, 0, 0, 0);

        // Mid-operation reset with 2 queued and a fetch pending
        step(0, 0, 0, 0, 0, 0);
        repeat (2) step(1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        repeat (4) step(1, 1, 1, 0, 0, 0);

        // Address wrap
        step(1, 0, 0, 1, 32'hFFFF_FFFE, 0);
        step(1, 1, 0, 0, 0, 0);
        repeat (4) step(1, 1, 1, 0, 0, 0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 39) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 15) == 0),
                 $urandom,
                 ($urandom_range(0, 79) == 0));
        end

        repeat (3) @(negedge clk);
        if (sb_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
